// File: rtl/fixed_div_seq_pkg.sv
// Shared SQm.n constants and helpers for the fixed-point divider and its reciprocal sibling.
// Both blocks must agree bit-for-bit on the saturation magnitude.
package fixed_div_seq_pkg;
  localparam int M  = 12;
  localparam int N  = 12;
  localparam int QW = M + N;
  localparam int W  = M + 2 * N;
  localparam int CW = $clog2(W);

  typedef logic [QW-1:0] qword_t;

  localparam qword_t NSAT = {1'b0, {(QW-1){1'b1}}};

  // Magnitude as unsigned; the most negative value maps onto 2^(QW-1), which still fits.
  function automatic qword_t abs_q(input qword_t x);
    return x[QW-1] ? qword_t'(-x) : x;
  endfunction

  function automatic qword_t neg_q(input qword_t x);
    return qword_t'(-x);
  endfunction
endpackage

// File: rtl/fixed_div_seq_if.sv
// Start/done request bus of the sequential divider.
interface fixed_div_seq_if;
  logic                        start;
  fixed_div_seq_pkg::qword_t   num;
  fixed_div_seq_pkg::qword_t   den;
  logic                        abs_mode;
  logic                        busy;
  logic                        done;
  fixed_div_seq_pkg::qword_t   quot;
  logic                        sat;
  logic                        div0;

  modport master (
    output start, num, den, abs_mode,
    input  busy, done, quot, sat, div0
  );

  modport slave (
    input  start, num, den, abs_mode,
    output busy, done, quot, sat, div0
  );
endinterface

// File: rtl/fixed_div_seq_div_step.sv
// One combinational restoring-division stage: ({rem,bit}, den) -> (rem', qbit).
// Kept standalone so a multi-bit-per-clock variant can chain several copies.
module fixed_div_seq_div_step
  import fixed_div_seq_pkg::*;
(
  input  qword_t rem_in,
  input  logic   bit_in,
  input  qword_t den,
  output qword_t rem_out,
  output logic   qbit
);
  logic [QW:0] shifted;
  qword_t      diff;

  assign shifted = {rem_in, bit_in};
  assign qbit    = (shifted >= {1'b0, den});
  // Only taken when shifted >= den, so the result is below den and fits QW bits.
  assign diff    = qword_t'(shifted[QW-1:0] - den);
  assign rem_out = qbit ? diff : shifted[QW-1:0];
endmodule

// File: rtl/fixed_div_seq.sv
// Sequential SQm.n divider, radix-2 restoring, one quotient bit per clock, truncation toward zero.
module fixed_div_seq
  import fixed_div_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  fixed_div_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, DIV, FIN} state_t;

  state_t          state_reg, state_next;
  logic            sign_reg;
  logic            abs_reg;
  qword_t          den_reg;
  qword_t          rem_reg;
  logic [W-1:0]    dvd_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            done_reg;
  qword_t          quot_reg;
  logic            sat_reg;
  logic            div0_reg;

  qword_t          rem_step;
  logic            qbit_step;
  logic            ovf;
  logic            zden;
  qword_t          mag;
  qword_t          result;

  fixed_div_seq_div_step u_step (
    .rem_in  (rem_reg),
    .bit_in  (dvd_reg[W-1]),
    .den     (den_reg),
    .rem_out (rem_step),
    .qbit    (qbit_step)
  );

  // After W shifts dvd_reg holds the full-width quotient.
  assign ovf    = (dvd_reg > {{(W-QW){1'b0}}, NSAT});
  assign zden   = (den_reg == '0);
  assign mag    = (ovf || zden) ? NSAT : dvd_reg[QW-1:0];
  assign result = (sign_reg && !abs_reg) ? neg_q(mag) : mag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = (bus.den == '0) ? FIN : DIV;
      DIV:     if (cnt_reg == '0) state_next = FIN;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_reg <= 1'b0;
      abs_reg  <= 1'b0;
      den_reg  <= '0;
      rem_reg  <= '0;
      dvd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      quot_reg <= '0;
      sat_reg  <= 1'b0;
      div0_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sign_reg <= bus.num[QW-1] ^ bus.den[QW-1];
            abs_reg  <= bus.abs_mode;
            den_reg  <= abs_q(bus.den);
            rem_reg  <= '0;
            dvd_reg  <= {abs_q(bus.num), {N{1'b0}}};
            cnt_reg  <= CW'(W - 1);
            busy_reg <= 1'b1;
            sat_reg  <= 1'b0;
            div0_reg <= 1'b0;
          end
        end
        DIV: begin
          rem_reg <= rem_step;
          dvd_reg <= {dvd_reg[W-2:0], qbit_step};
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        FIN: begin
          quot_reg <= result;
          sat_reg  <= ovf || zden;
          div0_reg <= zden;
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.quot = quot_reg;
  assign bus.sat  = sat_reg;
  assign bus.div0 = div0_reg;
endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed-vector bench for fixed_div_seq: table of hand-computed quotients plus handshake corner cases.
module tb_fixed_div_seq;
  import fixed_div_seq_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fixed_div_seq_if bus();

  fixed_div_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [23:0] num;
    logic [23:0] den;
    logic        abs_mode;
    logic [23:0] quot;
    logic        sat;
    logic        div0;
    int          lat;
  } vec_t;

  vec_t tbl[19];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drives one request and returns clocks from the sampling edge to the visible done pulse (-1 on timeout).
  task automatic run_op(input logic [23:0] n, input logic [23:0] d, input logic a, output int lat);
    int c;
    @(negedge clk);
    bus.num = n; bus.den = d; bus.abs_mode = a; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 0;
    while (bus.done !== 1'b1 && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    lat = (bus.done === 1'b1) ? c + 1 : -1;
    $display("op %h / %h abs=%b -> quot=%h sat=%b div0=%b lat=%0d",
             n, d, a, bus.quot, bus.sat, bus.div0, lat);
  endtask

  initial begin
    int lat;
    int t;
    logic seen;
    longint rq;
    logic [23:0] exp_q;
    logic exp_s;

    tbl[0]  = '{24'h001000, 24'h002000, 1'b0, 24'h000800, 1'b0, 1'b0, 38};
    tbl[1]  = '{24'hFFD000, 24'h001800, 1'b0, 24'hFFE000, 1'b0, 1'b0, 38};
    tbl[2]  = '{24'hFFD000, 24'h001800, 1'b1, 24'h002000, 1'b0, 1'b0, 38};
    tbl[3]  = '{24'h001000, 24'h003000, 1'b0, 24'h000555, 1'b0, 1'b0, 38};
    tbl[4]  = '{24'h7FF000, 24'h000100, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, 38};
    tbl[5]  = '{24'h800000, 24'h000100, 1'b0, 24'h800001, 1'b1, 1'b0, 38};
    tbl[6]  = '{24'h001000, 24'h000000, 1'b0, 24'h7FFFFF, 1'b1, 1'b1, 2};
    tbl[7]  = '{24'hFFF000, 24'h000000, 1'b0, 24'h800001, 1'b1, 1'b1, 2};
    tbl[8]  = '{24'h000000, 24'h001000, 1'b0, 24'h000000, 1'b0, 1'b0, 38};
    tbl[9]  = '{24'h000000, 24'hFFF000, 1'b0, 24'h000000, 1'b0, 1'b0, 38};
    tbl[10] = '{24'h7FFFFF, 24'h001000, 1'b0, 24'h7FFFFF, 1'b0, 1'b0, 38};
    tbl[11] = '{24'h800000, 24'hFFF000, 1'b0, 24'h7FFFFF, 1'b1, 1'b0, 38};
    tbl[12] = '{24'h003000, 24'hFFE000, 1'b0, 24'hFFE800, 1'b0, 1'b0, 38};
    tbl[13] = '{24'hFFF000, 24'h003000, 1'b0, 24'hFFFAAB, 1'b0, 1'b0, 38};
    tbl[14] = '{24'hFFF000, 24'h003000, 1'b1, 24'h000555, 1'b0, 1'b0, 38};
    tbl[15] = '{24'h800000, 24'h000100, 1'b1, 24'h7FFFFF, 1'b1, 1'b0, 38};
    tbl[16] = '{24'h000000, 24'h000000, 1'b0, 24'h7FFFFF, 1'b1, 1'b1, 2};
    tbl[17] = '{24'h800000, 24'h800000, 1'b0, 24'h001000, 1'b0, 1'b0, 38};
    tbl[18] = '{24'h000001, 24'h000003, 1'b0, 24'h000555, 1'b0, 1'b0, 38};

    reset_n = 1'b0;
    bus.start = 1'b0; bus.num = '0; bus.den = '0; bus.abs_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_quot", {40'd0, bus.quot}, 64'd0);
    check("rst_sat",  {63'd0, bus.sat},  64'd0);
    check("rst_div0", {63'd0, bus.div0}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      run_op(tbl[i].num, tbl[i].den, tbl[i].abs_mode, lat);
      check($sformatf("vec%0d_quot", i), {40'd0, bus.quot}, {40'd0, tbl[i].quot});
      check($sformatf("vec%0d_sat", i),  {63'd0, bus.sat},  {63'd0, tbl[i].sat});
      check($sformatf("vec%0d_div0", i), {63'd0, bus.div0}, {63'd0, tbl[i].div0});
      check($sformatf("vec%0d_lat", i),  64'(lat), 64'(tbl[i].lat));
    end

    // 1.0 / 2^j LSBs, reference from native integer division
    for (int j = 0; j < 23; j++) begin
      rq = (64'h1000 << 12) / (64'd1 << j);
      exp_s = (rq > 64'h7FFFFF);
      exp_q = exp_s ? 24'h7FFFFF : rq[23:0];
      run_op(24'h001000, 24'(32'd1 << j), 1'b0, lat);
      check($sformatf("recip%0d_quot", j), {40'd0, bus.quot}, {40'd0, exp_q});
      check($sformatf("recip%0d_sat", j),  {63'd0, bus.sat},  {63'd0, exp_s});
    end

    // Start held high: back-to-back ops, inputs changed mid-DIV must not disturb the op in flight
    @(negedge clk);
    bus.num = 24'h001000; bus.den = 24'h002000; bus.abs_mode = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    repeat (10) @(negedge clk);
    bus.num = 24'h006000;
    t = 0;
    while (bus.done !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    $display("held op1 -> quot=%h done=%b", bus.quot, bus.done);
    check("held_first_done", {63'd0, bus.done}, 64'd1);
    check("held_first_quot", {40'd0, bus.quot}, 64'h000800);
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
      if (t == 5) bus.num = 24'h00F000;
    end while (bus.done !== 1'b1 && t < 100);
    bus.start = 1'b0;
    $display("held op2 -> quot=%h period=%0d", bus.quot, t);
    check("held_period", 64'(t), 64'd38);
    check("held_second_quot", {40'd0, bus.quot}, 64'h003000);
    repeat (3) @(posedge clk);
    #1;
    check("held_no_third", {63'd0, bus.busy}, 64'd0);

    // Reset mid-operation aborts with no done pulse
    run_op(24'h002000, 24'h001000, 1'b0, lat);
    check("pre_abort_quot", {40'd0, bus.quot}, 64'h002000);
    @(negedge clk);
    bus.num = 24'h003000; bus.den = 24'h001000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    $display("abort -> quot=%h busy=%b done=%b", bus.quot, bus.busy, bus.done);
    check("abort_quot", {40'd0, bus.quot}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", {63'd0, seen}, 64'd0);
    run_op(24'h001000, 24'h003000, 1'b0, lat);
    check("post_abort_quot", {40'd0, bus.quot}, 64'h000555);
    check("post_abort_lat", 64'(lat), 64'd38);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
